// File: rtl/uart_frame_pkg.sv
// uart_frame_pkg: shared state type and constants
// for the UART frame controller.
package uart_frame_pkg;

  typedef enum logic [2:0] {
    IDLE,
    GET_OP,
    GET_LEN_H,
    GET_LEN_L,
    PAYLOAD,
    GET_CHK
  } frame_state_t;

  localparam logic [7:0] SYNC_BYTE   = 8'hA5;
  localparam logic [1:0] ERR_CHK     = 2'b01;
  localparam logic [1:0] ERR_LEN     = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT = 2'b11;

  // wide enough to count a full 2**16-byte payload
  localparam int CNT_W = 17;

endpackage

// File: rtl/uart_frame_if.sv
// uart_frame_if: byte input, buffer write port and
// command/error reporting of the frame controller.
interface uart_frame_if #(
  parameter int ADDR_W = 16
);

  logic [7:0]        rx_data;
  logic              rx_valid;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic              mem_we;
  logic              cmd_valid;
  logic [7:0]        cmd_op;
  logic [15:0]       cmd_len;
  logic              frame_err;
  logic [1:0]        err_code;
  logic              busy;

  modport master (
    output rx_data, rx_valid,
    input  mem_addr, mem_wdata, mem_we,
    input  cmd_valid, cmd_op, cmd_len,
    input  frame_err, err_code, busy
  );

  modport slave (
    input  rx_data, rx_valid,
    output mem_addr, mem_wdata, mem_we,
    output cmd_valid, cmd_op, cmd_len,
    output frame_err, err_code, busy
  );

endinterface

// File: rtl/uart_frame_ctrl_timer.sv
// frame_timeout_timer: inter-byte watchdog; expired
// pulses once the count sits at TIMEOUT_CLKS-1.
module frame_timeout_timer #(
  parameter int TIMEOUT_CLKS = 100_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  input  logic kick,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CLKS - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (!enable || kick) begin
      cnt_d = '0;
    end else if (cnt_q != LAST) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // a byte arriving on the terminal cycle wins
  assign expired = enable && !kick && (cnt_q == LAST);

endmodule

// File: rtl/uart_frame_ctrl.sv
// uart_frame_ctrl: parses SYNC/OP/LEN/payload/CHK frames,
// writes payload to the buffer and reports commands/errors.
module uart_frame_ctrl
  import uart_frame_pkg::*;
#(
  parameter int ADDR_W       = 16,
  parameter int TIMEOUT_CLKS = 100_000
) (
  input logic         clk,
  input logic         rst_n,
  uart_frame_if.slave io
);

  localparam logic [31:0] LEN_MAX = 32'd1 << ADDR_W;

  frame_state_t      state_q, state_d;
  logic [7:0]        chk_q, chk_d;
  logic [7:0]        op_q, op_d;
  logic [7:0]        lenh_q, lenh_d;
  logic [15:0]       len_q, len_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]        mem_wdata_q, mem_wdata_d;
  logic              mem_we_q, mem_we_d;
  logic              cmd_valid_q, cmd_valid_d;
  logic [7:0]        cmd_op_q, cmd_op_d;
  logic [15:0]       cmd_len_q, cmd_len_d;
  logic              frame_err_q, frame_err_d;
  logic [1:0]        err_code_q, err_code_d;
  logic              busy_q;
  logic              tmo_expired;
  logic [7:0]        rx_b;

  assign rx_b = io.rx_data;

  frame_timeout_timer #(
    .TIMEOUT_CLKS(TIMEOUT_CLKS)
  ) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .enable (state_q != IDLE),
    .kick   (io.rx_valid),
    .expired(tmo_expired)
  );

  always_comb begin
    state_d     = state_q;
    chk_d       = chk_q;
    op_d        = op_q;
    lenh_d      = lenh_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_we_d    = 1'b0;
    cmd_valid_d = 1'b0;
    cmd_op_d    = cmd_op_q;
    cmd_len_d   = cmd_len_q;
    frame_err_d = 1'b0;
    err_code_d  = err_code_q;
    if (io.rx_valid) begin
      unique case (state_q)
        IDLE: begin
          if (rx_b == SYNC_BYTE) begin
            chk_d   = '0;
            state_d = GET_OP;
          end
        end
        GET_OP: begin
          op_d    = rx_b;
          chk_d   = chk_q ^ rx_b;
          state_d = GET_LEN_H;
        end
        GET_LEN_H: begin
          lenh_d  = rx_b;
          chk_d   = chk_q ^ rx_b;
          state_d = GET_LEN_L;
        end
        GET_LEN_L: begin
          len_d = {lenh_q, rx_b};
          chk_d = chk_q ^ rx_b;
          if (32'(len_d) > LEN_MAX) begin
            frame_err_d = 1'b1;
            err_code_d  = ERR_LEN;
            state_d     = IDLE;
          end else if (len_d == '0) begin
            state_d = GET_CHK;
          end else begin
            cnt_d   = '0;
            state_d = PAYLOAD;
          end
        end
        PAYLOAD: begin
          // byte counter doubles as the write address
          mem_we_d    = 1'b1;
          mem_addr_d  = ADDR_W'(cnt_q);
          mem_wdata_d = rx_b;
          chk_d       = chk_q ^ rx_b;
          cnt_d       = cnt_q + CNT_W'(1);
          if (cnt_d == {1'b0, len_q}) begin
            state_d = GET_CHK;
          end
        end
        GET_CHK: begin
          state_d = IDLE;
          if (rx_b == chk_q) begin
            cmd_valid_d = 1'b1;
            cmd_op_d    = op_q;
            cmd_len_d   = len_q;
          end else begin
            frame_err_d = 1'b1;
            err_code_d  = ERR_CHK;
          end
        end
        default: state_d = IDLE;
      endcase
    end else if (tmo_expired) begin
      frame_err_d = 1'b1;
      err_code_d  = ERR_TIMEOUT;
      state_d     = IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      chk_q       <= '0;
      op_q        <= '0;
      lenh_q      <= '0;
      len_q       <= '0;
      cnt_q       <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
      cmd_valid_q <= 1'b0;
      cmd_op_q    <= '0;
      cmd_len_q   <= '0;
      frame_err_q <= 1'b0;
      err_code_q  <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      chk_q       <= chk_d;
      op_q        <= op_d;
      lenh_q      <= lenh_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_we_q    <= mem_we_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_op_q    <= cmd_op_d;
      cmd_len_q   <= cmd_len_d;
      frame_err_q <= frame_err_d;
      err_code_q  <= err_code_d;
      busy_q      <= (state_d != IDLE);
    end
  end

  assign io.mem_addr  = mem_addr_q;
  assign io.mem_wdata = mem_wdata_q;
  assign io.mem_we    = mem_we_q;
  assign io.cmd_valid = cmd_valid_q;
  assign io.cmd_op    = cmd_op_q;
  assign io.cmd_len   = cmd_len_q;
  assign io.frame_err = frame_err_q;
  assign io.err_code  = err_code_q;
  assign io.busy      = busy_q;

endmodule

// File: tb/tb_uart_frame_ctrl.sv
// tb_uart_frame_ctrl: frame controller bench with a
// stream-parsing reference model and event monitors.
module tb_uart_frame_ctrl;

  typedef logic [7:0] bq_t[$];
  typedef struct {
    int a;
    int d;
    int c;
  } ev_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   nchk = 0;
  int   nerr = 0;

  ev_t wr_q[$], cmd_q[$], err_q[$];
  ev_t wrb_q[$], cmdb_q[$], errb_q[$];
  int  edges[$];
  int  nogap[$];

  ev_t ew[$];
  int  e_kind, e_code, e_op, e_len, e_at;

  uart_frame_if #(.ADDR_W(16)) ia ();
  uart_frame_if #(.ADDR_W(8))  ib ();

  uart_frame_ctrl #(.ADDR_W(16), .TIMEOUT_CLKS(50)) ua (
    .clk(clk), .rst_n(rst_n), .io(ia.slave)
  );
  uart_frame_ctrl #(.ADDR_W(8), .TIMEOUT_CLKS(50)) ub (
    .clk(clk), .rst_n(rst_n), .io(ib.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n) begin
      if (ia.mem_we)
        wr_q.push_back('{int'(ia.mem_addr), int'(ia.mem_wdata), cyc});
      if (ia.cmd_valid)
        cmd_q.push_back('{int'(ia.cmd_op), int'(ia.cmd_len), cyc});
      if (ia.frame_err)
        err_q.push_back('{0, int'(ia.err_code), cyc});
      if (ib.mem_we)
        wrb_q.push_back('{int'(ib.mem_addr), int'(ib.mem_wdata), cyc});
      if (ib.cmd_valid)
        cmdb_q.push_back('{int'(ib.cmd_op), int'(ib.cmd_len), cyc});
      if (ib.frame_err)
        errb_q.push_back('{0, int'(ib.err_code), cyc});
    end
  end

  // Reference: locate SYNC, read header, slice payload, XOR-check.
  function automatic void model(input bq_t s, input int aw);
    int i;
    logic [7:0] x;
    ew.delete();
    e_kind = 0; e_code = 0; e_op = 0; e_len = 0; e_at = -1;
    i = 0;
    while (i < s.size() && s[i] != 8'hA5) i++;
    if (i + 3 >= s.size()) return;
    e_op  = int'(s[i+1]);
    e_len = int'({s[i+2], s[i+3]});
    x = s[i+1] ^ s[i+2] ^ s[i+3];
    if (e_len > (1 << aw)) begin
      e_kind = 2; e_code = 2; e_at = i + 3;
      return;
    end
    for (int k = 0; k < e_len && i + 4 + k < s.size(); k++) begin
      ew.push_back('{k, int'(s[i+4+k]), i + 4 + k});
      x = x ^ s[i+4+k];
    end
    if (i + 4 + e_len < s.size()) begin
      e_at = i + 4 + e_len;
      if (s[e_at] == x) e_kind = 1;
      else begin e_kind = 2; e_code = 1; end
    end
  endfunction

  function automatic bq_t mkframe(int op, int len, bit bad, int junk);
    bq_t s;
    logic [7:0] x, b;
    for (int j = 0; j < junk; j++) begin
      b = 8'($urandom);
      if (b == 8'hA5) b = 8'h5A;
      s.push_back(b);
    end
    s.push_back(8'hA5);
    s.push_back(8'(op));
    s.push_back(8'(len >> 8));
    s.push_back(8'(len));
    x = 8'(op) ^ 8'(len >> 8) ^ 8'(len);
    for (int j = 0; j < len; j++) begin
      b = 8'($urandom);
      s.push_back(b);
      x = x ^ b;
    end
    s.push_back(bad ? ~x : x);
    return s;
  endfunction

  task automatic drv(input bit sel, input logic v, input logic [7:0] d);
    if (sel) begin ib.rx_valid = v; ib.rx_data = d; end
    else begin ia.rx_valid = v; ia.rx_data = d; end
  endtask

  task automatic clear_q();
    wr_q.delete(); cmd_q.delete(); err_q.delete();
    wrb_q.delete(); cmdb_q.delete(); errb_q.delete();
    edges.delete();
  endtask

  task automatic send(input bit sel, input bq_t s, input int gaps[$]);
    for (int i = 0; i < s.size(); i++) begin
      int g;
      g = (i < gaps.size()) ? gaps[i] : 0;
      repeat (g) begin @(negedge clk); drv(sel, 1'b0, 8'h00); end
      @(negedge clk);
      drv(sel, 1'b1, s[i]);
      edges.push_back(cyc + 1);
    end
    @(negedge clk);
    drv(sel, 1'b0, 8'h00);
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset();
    logic [47:0] oa, ob;
    drv(0, 1'b0, 8'h00); drv(1, 1'b0, 8'h00);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    oa = {ia.mem_addr, ia.mem_wdata, ia.mem_we, ia.cmd_valid,
          ia.cmd_op, ia.cmd_len, ia.frame_err, ia.err_code, ia.busy};
    nchk++;
    if (oa !== '0) begin
      nerr++; $display("FAIL reset_a got=%h exp=0", oa);
    end
    ob = 48'({ib.mem_addr, ib.mem_wdata, ib.mem_we, ib.cmd_valid,
              ib.cmd_op, ib.cmd_len, ib.frame_err, ib.err_code, ib.busy});
    nchk++;
    if (ob !== '0) begin
      nerr++; $display("FAIL reset_b got=%h exp=0", ob);
    end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    nchk++;
    if (ia.busy !== 1'b0 || ia.mem_we !== 1'b0) begin
      nerr++; $display("FAIL idle_after_reset got=%b%b exp=00", ia.busy, ia.mem_we);
    end
  endtask

  task automatic test_good_frame();
    bq_t s;
    logic [7:0] dat[3];
    dat = '{8'h10, 8'h20, 8'h30};
    s = {8'hA5, 8'h01, 8'h00, 8'h03, 8'h10, 8'h20, 8'h30, 8'h02};
    clear_q();
    send(0, s, nogap);
    nchk++;
    if (wr_q.size() != 3) begin
      nerr++; $display("FAIL good_wr_count got=%0d exp=3", wr_q.size());
    end else begin
      for (int k = 0; k < 3; k++) begin
        nchk++;
        if (wr_q[k].a != k || wr_q[k].d != int'(dat[k]) || wr_q[k].c != edges[4+k]) begin
          nerr++;
          $display("FAIL good_wr%0d got=%0d/%h@%0d exp=%0d/%h@%0d", k,
                   wr_q[k].a, wr_q[k].d, wr_q[k].c, k, dat[k], edges[4+k]);
        end
      end
    end
    nchk++;
    if (cmd_q.size() != 1 || err_q.size() != 0) begin
      nerr++; $display("FAIL good_events got=cmd%0d err%0d exp=cmd1 err0", cmd_q.size(), err_q.size());
    end else begin
      nchk++;
      if (cmd_q[0].a != 1 || cmd_q[0].d != 3 || cmd_q[0].c != edges[7]) begin
        nerr++;
        $display("FAIL good_cmd got=%h/%0d@%0d exp=01/3@%0d", cmd_q[0].a, cmd_q[0].d, cmd_q[0].c, edges[7]);
      end
    end
    nchk++;
    if (ia.busy !== 1'b0) begin
      nerr++; $display("FAIL good_busy got=%b exp=0", ia.busy);
    end
  endtask

  task automatic test_bad_chk();
    bq_t s;
    s = {8'hA5, 8'h01, 8'h00, 8'h03, 8'h10, 8'h20, 8'h30, 8'h03};
    clear_q();
    send(0, s, nogap);
    nchk++;
    if (wr_q.size() != 3) begin
      nerr++; $display("FAIL badchk_wr_count got=%0d exp=3", wr_q.size());
    end
    nchk++;
    if (cmd_q.size() != 0 || err_q.size() != 1) begin
      nerr++; $display("FAIL badchk_events got=cmd%0d err%0d exp=cmd0 err1", cmd_q.size(), err_q.size());
    end else begin
      nchk++;
      if (err_q[0].d != 1 || err_q[0].c != edges[7]) begin
        nerr++; $display("FAIL badchk_err got=%0d@%0d exp=1@%0d", err_q[0].d, err_q[0].c, edges[7]);
      end
    end
    nchk++;
    if (ia.cmd_op !== 8'h01 || ia.cmd_len !== 16'd3 || ia.err_code !== 2'b01) begin
      nerr++;
      $display("FAIL badchk_hold got=%h/%0d/%b exp=01/3/01", ia.cmd_op, ia.cmd_len, ia.err_code);
    end
  endtask

  task automatic test_junk_len0();
    bq_t s;
    s = {8'h00, 8'hFF, 8'hA5, 8'h07, 8'h00, 8'h00, 8'h07};
    clear_q();
    send(0, s, nogap);
    nchk++;
    if (wr_q.size() != 0 || err_q.size() != 0 || cmd_q.size() != 1) begin
      nerr++;
      $display("FAIL len0_events got=wr%0d cmd%0d err%0d exp=wr0 cmd1 err0",
               wr_q.size(), cmd_q.size(), err_q.size());
    end else begin
      nchk++;
      if (cmd_q[0].a != 7 || cmd_q[0].d != 0 || cmd_q[0].c != edges[6]) begin
        nerr++;
        $display("FAIL len0_cmd got=%h/%0d@%0d exp=07/0@%0d", cmd_q[0].a, cmd_q[0].d, cmd_q[0].c, edges[6]);
      end
    end
  endtask

  task automatic test_oversize();
    bq_t s;
    s = {8'hA5, 8'h01, 8'h01, 8'h01};
    clear_q();
    send(1, s, nogap);
    nchk++;
    if (errb_q.size() != 1 || wrb_q.size() != 0) begin
      nerr++; $display("FAIL over_events got=err%0d wr%0d exp=err1 wr0", errb_q.size(), wrb_q.size());
    end else begin
      nchk++;
      if (errb_q[0].d != 2 || errb_q[0].c != edges[3]) begin
        nerr++; $display("FAIL over_err got=%0d@%0d exp=2@%0d", errb_q[0].d, errb_q[0].c, edges[3]);
      end
    end
    nchk++;
    if (ib.busy !== 1'b0) begin
      nerr++; $display("FAIL over_busy got=%b exp=0", ib.busy);
    end
    // exactly 2**ADDR_W bytes is legal
    clear_q();
    send(1, mkframe(8'h33, 256, 1'b0, 0), nogap);
    nchk++;
    if (wrb_q.size() != 256 || cmdb_q.size() != 1 || errb_q.size() != 0) begin
      nerr++;
      $display("FAIL max_len_events got=wr%0d cmd%0d err%0d exp=wr256 cmd1 err0",
               wrb_q.size(), cmdb_q.size(), errb_q.size());
    end else begin
      nchk++;
      if (wrb_q[255].a != 255 || cmdb_q[0].a != 8'h33 || cmdb_q[0].d != 256) begin
        nerr++;
        $display("FAIL max_len got=%0d/%h/%0d exp=255/33/256", wrb_q[255].a, cmdb_q[0].a, cmdb_q[0].d);
      end
    end
  endtask

  task automatic test_timeout();
    bq_t s;
    s = {8'hA5, 8'h01};
    clear_q();
    send(0, s, nogap);
    repeat (60) @(negedge clk);
    nchk++;
    if (err_q.size() != 1) begin
      nerr++; $display("FAIL tmo_count got=%0d exp=1", err_q.size());
    end else begin
      nchk++;
      if (err_q[0].d != 3 || err_q[0].c != edges[1] + 50) begin
        nerr++; $display("FAIL tmo_err got=%0d@%0d exp=3@%0d", err_q[0].d, err_q[0].c, edges[1] + 50);
      end
    end
    nchk++;
    if (ia.busy !== 1'b0) begin
      nerr++; $display("FAIL tmo_busy got=%b exp=0", ia.busy);
    end
    clear_q();
    send(0, mkframe(8'h42, 2, 1'b0, 0), nogap);
    nchk++;
    if (cmd_q.size() != 1 || err_q.size() != 0) begin
      nerr++; $display("FAIL tmo_recover got=cmd%0d err%0d exp=cmd1 err0", cmd_q.size(), err_q.size());
    end
  endtask

  task automatic test_timeout_race();
    bq_t s;
    int g[$];
    s = {8'hA5, 8'h05, 8'h00, 8'h01, 8'hAB, 8'hAF};
    for (int gap = 49; gap <= 50; gap++) begin
      g.delete(); g.push_back(0); g.push_back(gap);
      clear_q();
      send(0, s, g);
      nchk++;
      if (gap == 49 && (cmd_q.size() != 1 || err_q.size() != 0)) begin
        nerr++; $display("FAIL race_rx_wins got=cmd%0d err%0d exp=cmd1 err0", cmd_q.size(), err_q.size());
      end else if (gap == 50 && (cmd_q.size() != 0 || err_q.size() != 1)) begin
        nerr++; $display("FAIL race_expire got=cmd%0d err%0d exp=cmd0 err1", cmd_q.size(), err_q.size());
      end else if (gap == 50 && (err_q[0].d != 3 || err_q[0].c != edges[0] + 50)) begin
        nerr++; $display("FAIL race_expire_at got=%0d@%0d exp=3@%0d", err_q[0].d, err_q[0].c, edges[0] + 50);
      end
    end
  endtask

  task automatic test_back_to_back();
    bq_t s;
    s = mkframe(int'($urandom_range(0, 255)), 4, 1'b0, 0);
    model(s, 16);
    clear_q();
    send(0, s, nogap);
    nchk++;
    if (wr_q.size() != 4) begin
      nerr++; $display("FAIL b2b_wr_count got=%0d exp=4", wr_q.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        nchk++;
        if (wr_q[k].c != wr_q[0].c + k || wr_q[k].d != ew[k].d || wr_q[k].a != k) begin
          nerr++;
          $display("FAIL b2b_wr%0d got=%0d/%h@%0d exp=%0d/%h@%0d", k,
                   wr_q[k].a, wr_q[k].d, wr_q[k].c, k, ew[k].d, wr_q[0].c + k);
        end
      end
    end
    nchk++;
    if (cmd_q.size() != 1) begin
      nerr++; $display("FAIL b2b_cmd got=%0d exp=1", cmd_q.size());
    end
  endtask

  task automatic test_random();
    bq_t s;
    int g[$];
    int bad;
    for (int it = 0; it < 25; it++) begin
      s = mkframe(int'($urandom_range(0, 255)), int'($urandom_range(0, 12)),
                  ($urandom_range(0, 3) == 0), int'($urandom_range(0, 2)));
      g.delete();
      foreach (s[i]) g.push_back(int'($urandom_range(0, 3)));
      model(s, 16);
      clear_q();
      send(0, s, g);
      bad = 0;
      if (wr_q.size() != ew.size()) bad = 1;
      else foreach (ew[k])
        if (wr_q[k].a != ew[k].a || wr_q[k].d != ew[k].d || wr_q[k].c != edges[ew[k].c]) bad = 1;
      nchk++;
      if (bad != 0) begin
        nerr++; $display("FAIL rand%0d_writes got=%0d exp=%0d", it, wr_q.size(), ew.size());
      end
      nchk++;
      if (e_kind == 1) begin
        if (cmd_q.size() != 1 || err_q.size() != 0 || cmd_q[0].a != e_op ||
            cmd_q[0].d != e_len || cmd_q[0].c != edges[e_at]) begin
          nerr++; $display("FAIL rand%0d_cmd got=cmd%0d err%0d exp=%h/%0d", it,
                           cmd_q.size(), err_q.size(), e_op, e_len);
        end
      end else begin
        if (cmd_q.size() != 0 || err_q.size() != 1 || err_q[0].d != e_code ||
            err_q[0].c != edges[e_at]) begin
          nerr++; $display("FAIL rand%0d_err got=cmd%0d err%0d exp=code%0d", it,
                           cmd_q.size(), err_q.size(), e_code);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    bq_t s;
    logic [47:0] oa;
    s = {8'hA5, 8'h02, 8'h00, 8'h08, 8'h11, 8'h22, 8'h33};
    clear_q();
    send(0, s, nogap);
    #2 rst_n = 1'b0;
    #1;
    oa = {ia.mem_addr, ia.mem_wdata, ia.mem_we, ia.cmd_valid,
          ia.cmd_op, ia.cmd_len, ia.frame_err, ia.err_code, ia.busy};
    nchk++;
    if (oa !== '0) begin
      nerr++; $display("FAIL midreset_outputs got=%h exp=0", oa);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (60) @(negedge clk);
    nchk++;
    if (ia.busy !== 1'b0 || err_q.size() != 0 || cmd_q.size() != 0) begin
      nerr++; $display("FAIL midreset_quiet got=busy%b err%0d cmd%0d exp=busy0 err0 cmd0",
                       ia.busy, err_q.size(), cmd_q.size());
    end
  endtask

  initial begin
    ia.rx_valid = 1'b0; ia.rx_data = 8'h00;
    ib.rx_valid = 1'b0; ib.rx_data = 8'h00;
    test_reset();
    test_good_frame();
    test_bad_chk();
    test_junk_len0();
    test_oversize();
    test_timeout();
    test_timeout_race();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
